// File: rtl/mcb_resp_pkg.sv
// Shared encodings, FSM state type and packed word layouts for the MCB port responder.
package mcb_resp_pkg;

  localparam logic [2:0] INSTR_WR    = 3'b000;
  localparam logic [2:0] INSTR_RD    = 3'b001;
  localparam logic [2:0] INSTR_WR_AP = 3'b010;
  localparam logic [2:0] INSTR_RD_AP = 3'b011;
  localparam logic [2:0] INSTR_REF   = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_READ    = 2'd2,
    ST_REFRESH = 2'd3
  } state_t;

  // Two spare bits keep the command word at the 41-bit FIFO width.
  typedef struct packed {
    logic [1:0]  spare;
    logic [2:0]  instr;
    logic [5:0]  bl;
    logic [29:0] byte_addr;
  } cmd_t;

  typedef struct packed {
    logic [3:0]  mask;
    logic [31:0] data;
  } wr_word_t;

  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mcb_port_responder_if.sv
// One MCB-style user port: master is the dma initiator, slave is the memory-side responder.
interface mcb_port_if #(
  parameter int CNT_W = 7
);
  logic              calib_done;
  logic              cmd_en;
  logic [2:0]        cmd_instr;
  logic [5:0]        cmd_bl;
  logic [29:0]       cmd_byte_addr;
  logic              cmd_empty;
  logic              cmd_full;
  logic              wr_en;
  logic [3:0]        wr_mask;
  logic [31:0]       wr_data;
  logic              wr_full;
  logic              wr_empty;
  logic [CNT_W-1:0]  wr_count;
  logic              wr_underrun;
  logic              wr_error;
  logic              rd_en;
  logic [31:0]       rd_data;
  logic              rd_full;
  logic              rd_empty;
  logic [CNT_W-1:0]  rd_count;
  logic              rd_overflow;
  logic              rd_error;

  modport master (
    input  calib_done, cmd_empty, cmd_full,
    input  wr_full, wr_empty, wr_count, wr_underrun, wr_error,
    input  rd_data, rd_full, rd_empty, rd_count, rd_overflow, rd_error,
    output cmd_en, cmd_instr, cmd_bl, cmd_byte_addr,
    output wr_en, wr_mask, wr_data, rd_en
  );

  modport slave (
    output calib_done, cmd_empty, cmd_full,
    output wr_full, wr_empty, wr_count, wr_underrun, wr_error,
    output rd_data, rd_full, rd_empty, rd_count, rd_overflow, rd_error,
    input  cmd_en, cmd_instr, cmd_bl, cmd_byte_addr,
    input  wr_en, wr_mask, wr_data, rd_en
  );

endinterface

// File: rtl/mcb_sync_fifo.sv
// First-word-fall-through synchronous FIFO with registered count/full/empty.
module mcb_sync_fifo
  import mcb_resp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [WIDTH-1:0]              push_data,
  input  logic                          pop,
  output logic [WIDTH-1:0]              pop_data,
  output logic [count_width(DEPTH)-1:0] count,
  output logic                          full,
  output logic                          empty
);

  localparam int CW = count_width(DEPTH);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             full_r;
  logic             empty_r;
  logic             push_ok_s;
  logic             pop_ok_s;
  logic [CW-1:0]    count_nxt_s;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
    if (ptr == PW'(DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return ptr + PW'(1'b1);
    end
  endfunction

  // Pushes into a full FIFO and pops from an empty one are ignored.
  always_comb begin
    push_ok_s   = push & ~full_r;
    pop_ok_s    = pop & ~empty_r;
    count_nxt_s = count_r;
    if (push_ok_s && !pop_ok_s) begin
      count_nxt_s = count_r + CW'(1'b1);
    end else if (pop_ok_s && !push_ok_s) begin
      count_nxt_s = count_r - CW'(1'b1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Pointers and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= ptr_next(wr_ptr_r);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ptr_next(rd_ptr_r);
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == CW'(DEPTH));
      empty_r <= (count_nxt_s == {CW{1'b0}});
    end
  end

  // Storage array, never reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  assign pop_data = empty_r ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];
  assign count    = count_r;
  assign full     = full_r;
  assign empty    = empty_r;

endmodule

// File: rtl/mcb_port_responder.sv
// RAM-backed stand-in for an MCB user port: command/write/read FIFOs, a burst FSM,
// a calibration delay and sticky error flags.
module mcb_port_responder
  import mcb_resp_pkg::*;
#(
  parameter int MEM_WORDS_LOG2 = 12,
  parameter int CMD_DEPTH      = 4,
  parameter int DATA_DEPTH     = 64,
  parameter int CALIB_CYCLES   = 16,
  parameter int REFRESH_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  mcb_port_if.slave  port
);

  localparam int AW        = MEM_WORDS_LOG2;
  localparam int CNT_W     = count_width(DATA_DEPTH);
  localparam int CMD_CNT_W = count_width(CMD_DEPTH);
  localparam int SUM_W     = CNT_W + 1;
  localparam int CAL_W     = $clog2(CALIB_CYCLES + 1);
  localparam int REF_W     = $clog2(REFRESH_CYCLES + 1);

  cmd_t                 cmd_in_s;
  cmd_t                 cmd_head_s;
  logic                 cmd_push_s;
  logic                 cmd_pop_s;
  logic                 cmd_empty_s;
  logic                 cmd_full_s;
  logic [CMD_CNT_W-1:0] cmd_count_s;
  wr_word_t             wr_head_s;
  logic                 wr_pop_s;
  logic                 wr_empty_s;
  logic                 wr_full_s;
  logic [CNT_W-1:0]     wr_count_s;
  logic                 rd_empty_s;
  logic                 rd_full_s;
  logic [CNT_W-1:0]     rd_count_s;
  logic                 wr_ready_s;
  logic                 rd_ready_s;
  logic                 ram_re_s;
  logic                 unused_s;

  state_t               state_r;
  logic [5:0]           beat_r;
  logic [5:0]           bl_r;
  logic [AW-1:0]        addr_r;
  logic [REF_W-1:0]     ref_cnt_r;
  logic [CAL_W-1:0]     calib_cnt_r;
  logic                 calib_done_r;
  logic                 rd_valid_r;
  logic [31:0]          ram_q_r;
  logic                 wr_underrun_r;
  logic                 wr_error_r;
  logic                 rd_error_r;
  logic                 rd_overflow_r;
  logic [31:0]          ram_r [2**AW];

  assign cmd_in_s   = {2'b00, port.cmd_instr, port.cmd_bl, port.cmd_byte_addr};
  assign cmd_push_s = port.cmd_en & calib_done_r;

  mcb_sync_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk(clk), .reset(reset),
    .push(cmd_push_s), .push_data(cmd_in_s),
    .pop(cmd_pop_s), .pop_data(cmd_head_s),
    .count(cmd_count_s), .full(cmd_full_s), .empty(cmd_empty_s)
  );

  mcb_sync_fifo #(.WIDTH($bits(wr_word_t)), .DEPTH(DATA_DEPTH)) u_wr_fifo (
    .clk(clk), .reset(reset),
    .push(port.wr_en), .push_data({port.wr_mask, port.wr_data}),
    .pop(wr_pop_s), .pop_data(wr_head_s),
    .count(wr_count_s), .full(wr_full_s), .empty(wr_empty_s)
  );

  mcb_sync_fifo #(.WIDTH(32), .DEPTH(DATA_DEPTH)) u_rd_fifo (
    .clk(clk), .reset(reset),
    .push(rd_valid_r), .push_data(ram_q_r),
    .pop(port.rd_en), .pop_data(port.rd_data),
    .count(rd_count_s), .full(rd_full_s), .empty(rd_empty_s)
  );

  // Start gating and per-cycle FIFO/RAM strobes; a read in flight counts against read space.
  always_comb begin
    wr_ready_s = (SUM_W'(wr_count_s) >= (SUM_W'(cmd_head_s.bl) + SUM_W'(1'b1)));
    rd_ready_s = ((SUM_W'(rd_count_s) + SUM_W'(rd_valid_r) + SUM_W'(cmd_head_s.bl)
                   + SUM_W'(1'b1)) <= SUM_W'(DATA_DEPTH));
    cmd_pop_s  = 1'b0;
    wr_pop_s   = 1'b0;
    ram_re_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!cmd_empty_s) begin
          case (cmd_head_s.instr)
            INSTR_WR, INSTR_WR_AP: cmd_pop_s = wr_ready_s;
            INSTR_RD, INSTR_RD_AP: cmd_pop_s = rd_ready_s;
            default:               cmd_pop_s = 1'b1;
          endcase
        end else begin
          cmd_pop_s = 1'b0;
        end
      end
      ST_WRITE: wr_pop_s = ~wr_empty_s;
      ST_READ:  ram_re_s = 1'b1;
      default: begin
        cmd_pop_s = 1'b0;
        wr_pop_s  = 1'b0;
        ram_re_s  = 1'b0;
      end
    endcase
  end

  // Burst FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      beat_r        <= 6'd0;
      bl_r          <= 6'd0;
      addr_r        <= {AW{1'b0}};
      ref_cnt_r     <= {REF_W{1'b0}};
      wr_underrun_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_pop_s) begin
            beat_r    <= 6'd0;
            bl_r      <= cmd_head_s.bl;
            addr_r    <= cmd_head_s.byte_addr[AW+1:2];
            ref_cnt_r <= {REF_W{1'b0}};
            case (cmd_head_s.instr)
              INSTR_WR, INSTR_WR_AP: state_r <= ST_WRITE;
              INSTR_RD, INSTR_RD_AP: state_r <= ST_READ;
              INSTR_REF:             state_r <= ST_REFRESH;
              default:               state_r <= ST_IDLE;
            endcase
          end
        end
        ST_WRITE: begin
          if (wr_pop_s) begin
            addr_r <= addr_r + AW'(1'b1);
            beat_r <= beat_r + 6'd1;
            if (beat_r == bl_r) begin
              state_r <= ST_IDLE;
            end
          end else begin
            wr_underrun_r <= 1'b1;
          end
        end
        ST_READ: begin
          addr_r <= addr_r + AW'(1'b1);
          beat_r <= beat_r + 6'd1;
          if (beat_r == bl_r) begin
            state_r <= ST_IDLE;
          end
        end
        ST_REFRESH: begin
          if (ref_cnt_r == REF_W'(REFRESH_CYCLES - 1)) begin
            state_r <= ST_IDLE;
          end else begin
            ref_cnt_r <= ref_cnt_r + REF_W'(1'b1);
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Backing RAM write port; a set mask bit protects that byte.
  always_ff @(posedge clk) begin
    if (wr_pop_s) begin
      for (int b = 0; b < 4; b++) begin
        if (!wr_head_s.mask[b]) begin
          ram_r[addr_r][8*b +: 8] <= wr_head_s.data[8*b +: 8];
        end
      end
    end
  end

  // Synchronous RAM read: the word reaches the read FIFO one cycle after issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_r <= 1'b0;
      ram_q_r    <= 32'd0;
    end else begin
      rd_valid_r <= ram_re_s;
      if (ram_re_s) begin
        ram_q_r <= ram_r[addr_r];
      end
    end
  end

  // Calibration delay after reset release.
  always_ff @(posedge clk) begin
    if (reset) begin
      calib_cnt_r  <= {CAL_W{1'b0}};
      calib_done_r <= 1'b0;
    end else if (!calib_done_r) begin
      calib_cnt_r <= calib_cnt_r + CAL_W'(1'b1);
      if (calib_cnt_r == CAL_W'(CALIB_CYCLES - 1)) begin
        calib_done_r <= 1'b1;
      end
    end
  end

  // Sticky host-side error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_error_r    <= 1'b0;
      rd_error_r    <= 1'b0;
      rd_overflow_r <= 1'b0;
    end else begin
      if (port.wr_en && wr_full_s) begin
        wr_error_r <= 1'b1;
      end
      if (port.rd_en && rd_empty_s) begin
        rd_error_r <= 1'b1;
      end
      if (rd_valid_r && rd_full_s) begin
        rd_overflow_r <= 1'b1;
      end
    end
  end

  assign unused_s = ^{cmd_count_s, cmd_head_s.spare,
                      cmd_head_s.byte_addr[29:AW+2], cmd_head_s.byte_addr[1:0]};

  assign port.calib_done  = calib_done_r;
  assign port.cmd_empty   = cmd_empty_s;
  assign port.cmd_full    = cmd_full_s;
  assign port.wr_full     = wr_full_s;
  assign port.wr_empty    = wr_empty_s;
  assign port.wr_count    = wr_count_s;
  assign port.wr_underrun = wr_underrun_r;
  assign port.wr_error    = wr_error_r;
  assign port.rd_full     = rd_full_s;
  assign port.rd_empty    = rd_empty_s;
  assign port.rd_count    = rd_count_s;
  assign port.rd_overflow = rd_overflow_r;
  assign port.rd_error    = rd_error_r;

endmodule
